burst_dma_writer: RTL

Parametrised burst DMA write engine: queues (start address, length) commands, drains a first-word-fall-through data FIFO, and writes the data to SDRAM over an Avalon-MM master using `burstcount` bursts. It sits between the line-capture data FIFO and the SDRAM controller, as the burst-capable successor of the single-beat DMA. It adds configurable data, address and burst widths, an internal command queue of configurable depth, burst splitting of long buffers, zero-length command handling and command-overflow reporting.

---
 rtl/dma_pkg.sv | 27 ++
 rtl/dma_cmd_fifo.sv | 55 +++++
 rtl/burst_dma_writer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared types for the burst DMA writer: FSM state encoding, the queued command
// record and the burst sizing helper.
package dma_pkg;

    // Command fields are carried at this width; ADDR_W must not exceed it.
    localparam int CMD_FIELD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ARB   = 2'd2,
        ST_BURST = 2'd3
    } dma_state_e;

    typedef struct packed {
        logic [CMD_FIELD_W-1:0] size;
        logic [CMD_FIELD_W-1:0] adr;
    } dma_cmd_t;

    function automatic logic [CMD_FIELD_W-1:0] min_beats(
        input logic [CMD_FIELD_W-1:0] rem,
        input logic [CMD_FIELD_W-1:0] burst_max
    );
        return (rem < burst_max) ? rem : burst_max;
    endfunction

endpackage

// File: rtl/dma_cmd_fifo.sv
// Register-based command queue with registered read data; the popped entry is
// visible on rd_data the cycle after rd_en.
module dma_cmd_fifo #(
    parameter int WIDTH      = 64,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]    rd_data_q, rd_data_d;
    logic                do_wr, do_rd;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
                   (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;
    assign rd_data = rd_data_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, do_wr};
        rd_ptr_d  = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, do_rd};
        rd_data_d = do_rd ? mem_q[rd_ptr_q[DEPTH_LOG2-1:0]] : rd_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
    end

endmodule

// File: rtl/burst_dma_writer.sv
// Burst DMA write engine: queues (address, length) commands and streams an FWFT
// data FIFO to an Avalon-MM master in bursts of at most BURST_MAX beats.
module burst_dma_writer
    import dma_pkg::*;
#(
    parameter int DATA_W         = 128,
    parameter int ADDR_W         = 28,
    parameter int BURST_MAX      = 8,
    parameter int CMD_DEPTH_LOG2 = 3,
    parameter int CNT_W          = 11
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic [ADDR_W-1:0]            START_ADR,
    input  logic [ADDR_W-1:0]            BUF_SIZE,
    input  logic                         START,
    output logic [15:0]                  DONE_CNT,
    output logic                         BUSY,
    output logic                         CMD_FULL,
    output logic                         CMD_EMPTY,
    output logic                         CMD_OVF,
    input  logic [DATA_W-1:0]            FIFO_DATA,
    input  logic [CNT_W-1:0]             FIFO_DATA_CNT,
    output logic                         FIFO_TREADY,
    output logic [ADDR_W-1:0]            SDRAM_ADDRESS,
    output logic [$clog2(BURST_MAX):0]   SDRAM_BURSTCOUNT,
    output logic [DATA_W-1:0]            SDRAM_WRITEDATA,
    output logic                         SDRAM_WRITE,
    input  logic                         SDRAM_WAITREQUEST
);

    localparam int BC_W = $clog2(BURST_MAX) + 1;

    dma_state_e        state_q, state_d;
    logic              start_s_q, start_p_q;
    logic              start_rise;
    logic              ovf_q, ovf_d;
    logic [15:0]       done_q, done_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BC_W-1:0]   bc_q, bc_d;
    logic [BC_W-1:0]   beat_q, beat_d;
    logic              write_q, write_d;
    logic [BC_W-1:0]   beats;
    logic              data_ok;
    logic              beat_acc;
    logic              cmd_pop, cmd_full, cmd_empty;
    dma_cmd_t          cmd_push, cmd_head;
    logic              unused_cmd_bits;

    assign start_rise = start_s_q & ~start_p_q;

    always_comb begin
        cmd_push      = '0;
        cmd_push.size = CMD_FIELD_W'(BUF_SIZE);
        cmd_push.adr  = CMD_FIELD_W'(START_ADR);
    end

    // Full is checked before any same-cycle pop, so a full queue drops the command.
    dma_cmd_fifo #(
        .WIDTH      ($bits(dma_cmd_t)),
        .DEPTH_LOG2 (CMD_DEPTH_LOG2)
    ) u_cmd_fifo (
        .clk     (CLK),
        .rst_n   (RST_N),
        .wr_en   (start_rise),
        .wr_data (cmd_push),
        .rd_en   (cmd_pop),
        .rd_data (cmd_head),
        .full    (cmd_full),
        .empty   (cmd_empty)
    );

    // Upper command bits above ADDR_W are always zero.
    assign unused_cmd_bits = ^{cmd_head.size, cmd_head.adr};

    assign beats    = BC_W'(min_beats(CMD_FIELD_W'(rem_q), CMD_FIELD_W'(BURST_MAX)));
    assign data_ok  = CMD_FIELD_W'(FIFO_DATA_CNT) >= CMD_FIELD_W'(beats);
    assign beat_acc = write_q & ~SDRAM_WAITREQUEST;

    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q | (start_rise & cmd_full);
        done_d  = done_q;
        adr_d   = adr_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        bc_d    = bc_q;
        beat_d  = beat_q;
        write_d = write_q;
        cmd_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!cmd_empty) begin
                    cmd_pop = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                adr_d = cmd_head.adr[ADDR_W-1:0];
                rem_d = cmd_head.size[ADDR_W-1:0];
                if (cmd_head.size[ADDR_W-1:0] == '0) begin
                    done_d  = done_q + 16'd1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                // Whole burst must be present so the burst never starves mid-way.
                if (data_ok) begin
                    addr_d  = adr_q;
                    bc_d    = beats;
                    beat_d  = '0;
                    write_d = 1'b1;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (beat_acc) begin
                    beat_d = beat_q + BC_W'(1);
                    if (beat_q == bc_q - BC_W'(1)) begin
                        write_d = 1'b0;
                        adr_d   = adr_q + ADDR_W'(bc_q);
                        rem_d   = rem_q - ADDR_W'(bc_q);
                        if (rem_q == ADDR_W'(bc_q)) begin
                            done_d  = done_q + 16'd1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_ARB;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            start_s_q <= 1'b0;
            start_p_q <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= '0;
            adr_q     <= '0;
            rem_q     <= '0;
            addr_q    <= '0;
            bc_q      <= '0;
            beat_q    <= '0;
            write_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_s_q <= START;
            start_p_q <= start_s_q;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
            adr_q     <= adr_d;
            rem_q     <= rem_d;
            addr_q    <= addr_d;
            bc_q      <= bc_d;
            beat_q    <= beat_d;
            write_q   <= write_d;
        end
    end

    assign DONE_CNT         = done_q;
    assign BUSY             = (state_q != ST_IDLE);
    assign CMD_FULL         = cmd_full;
    assign CMD_EMPTY        = cmd_empty;
    assign CMD_OVF          = ovf_q;
    assign SDRAM_ADDRESS    = addr_q;
    assign SDRAM_BURSTCOUNT = bc_q;
    assign SDRAM_WRITE      = write_q;
    assign SDRAM_WRITEDATA  = FIFO_DATA;
    assign FIFO_TREADY      = beat_acc;

endmodule
